// File: rtl/dmem_mmio_if.sv
// Data-port bus between the pipelined MIPS core and the dmem_mmio subsystem.
// The core drives address/data/strobe; the memory returns combinational load data.
interface dmem_mmio_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] write_data;
  logic             mem_write;
  logic [WIDTH-1:0] read_data;

  modport master (output mem_addr, output write_data, output mem_write, input  read_data);
  modport slave  (input  mem_addr, input  write_data, input  mem_write, output read_data);
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO (LED, TX FIFO, STATUS, CYCLE) behind the core's single-cycle data port.
// Define DMEM_MMIO_CYCLE_EN to build the free-running CYCLE counter; otherwise CYCLE reads 0.
module dmem_mmio #(
  parameter int WIDTH   = 32,
  parameter int RAM_AW  = 6,
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  dmem_mmio_if.slave bus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] led
);

  localparam int DEPTH     = 1 << FIFO_AW;
  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam logic [2:0] SEL_LED    = 3'd0;
  localparam logic [2:0] SEL_TX     = 3'd1;
  localparam logic [2:0] SEL_STATUS = 3'd2;
  localparam logic [2:0] SEL_CYCLE  = 3'd3;
  localparam logic [FIFO_AW-1:0] PTR_ONE    = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE    = 1;
  localparam logic [FIFO_AW:0]   FULL_COUNT = DEPTH[FIFO_AW:0];

  logic              is_mmio;
  logic              mmio_wr;
  logic [2:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr;

  assign is_mmio     = bus.mem_addr[WIDTH-1];
  assign reg_sel     = bus.mem_addr[4:2];
  assign ram_idx     = bus.mem_addr[RAM_AW+1:2];
  assign mmio_wr     = bus.mem_write && is_mmio;
  assign unused_addr = ^bus.mem_addr;

  // RAM is deliberately left out of reset so it maps onto plain memory macros.
  logic [WIDTH-1:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (bus.mem_write && !is_mmio) begin
      ram[ram_idx] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= '0;
    end else if (mmio_wr && reg_sel == SEL_LED) begin
      led <= bus.write_data[7:0];
    end
  end

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty;
  logic               full;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               overflow;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push_req = mmio_wr && reg_sel == SEL_TX;
  // A pop in the same cycle frees the head slot, so a push at full is still accepted.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.write_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      if (push_req && !push) begin
        overflow <= 1'b1;
      end else if (mmio_wr && reg_sel == SEL_STATUS && bus.write_data[2]) begin
        overflow <= 1'b0;
      end
    end
  end

  logic [WIDTH-1:0] cycle_rd;

`ifdef DMEM_MMIO_CYCLE_EN
  localparam logic [WIDTH-1:0] CYC_ONE = 1;
  logic [WIDTH-1:0] cycle_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (mmio_wr && reg_sel == SEL_CYCLE) begin
      cycle_count <= bus.write_data;
    end else begin
      cycle_count <= cycle_count + CYC_ONE;
    end
  end

  assign cycle_rd = cycle_count;
`else
  assign cycle_rd = '0;
`endif

  logic [WIDTH-1:0] status;

  always_comb begin
    status              = '0;
    status[0]           = empty;
    status[1]           = full;
    status[2]           = overflow;
    status[FIFO_AW+8:8] = count;
  end

  always_comb begin
    bus.read_data = '0;
    if (!is_mmio) begin
      bus.read_data = ram[ram_idx];
    end else begin
      case (reg_sel)
        SEL_LED:    bus.read_data = {{(WIDTH-8){1'b0}}, led};
        SEL_STATUS: bus.read_data = status;
        SEL_CYCLE:  bus.read_data = cycle_rd;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus a randomized run against
// a queue/array reference model. Honours DMEM_MMIO_CYCLE_EN the same way as the design.
module tb_dmem_mmio;

  localparam int WIDTH   = 32;
  localparam int RAM_AW  = 6;
  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 8;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_TX     = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_CYCLE  = 32'h8000_000C;
  localparam logic [31:0] A_IDLE   = 32'h8000_0010;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] led;

  dmem_mmio_if #(.WIDTH(WIDTH)) bus ();

  dmem_mmio #(.WIDTH(WIDTH), .RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .led      (led)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ram_m [64];
  bit          ram_known [64];
  logic [7:0]  q [$];
  logic [7:0]  led_m;
  bit          ovf_m;
  logic [31:0] cyc_m;

  int passes = 0;
  int checks = 0;

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s        = '0;
    s[0]     = (q.size() == 0);
    s[1]     = (q.size() == DEPTH);
    s[2]     = ovf_m;
    s[11:8]  = 4'(q.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
    int idx;
    known = 1'b1;
    if (!a[31]) begin
      idx   = int'(a[7:2]);
      known = ram_known[idx];
      return ram_m[idx];
    end
    case (a[4:2])
      3'd0:    return {24'h0, led_m};
      3'd2:    return status_m();
`ifdef DMEM_MMIO_CYCLE_EN
      3'd3:    return cyc_m;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    led_m = 8'h00;
    ovf_m = 1'b0;
    cyc_m = 32'h0;
  endtask

  // Inputs change 1ns after the rising edge and settle for 1ns before any sampling.
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
    bus.mem_addr   = a;
    bus.write_data = d;
    bus.mem_write  = we;
    tx_ready       = rdy;
    #1;
  endtask

  task automatic tick();
    logic [31:0] a;
    logic [31:0] d;
    bit          full_b;
    bit          popd;
    a      = bus.mem_addr;
    d      = bus.write_data;
    full_b = (q.size() == DEPTH);
    popd   = tx_ready && (q.size() != 0);
    if (popd) void'(q.pop_front());
`ifdef DMEM_MMIO_CYCLE_EN
    cyc_m = cyc_m + 32'd1;
`endif
    if (bus.mem_write) begin
      if (!a[31]) begin
        ram_m[int'(a[7:2])]     = d;
        ram_known[int'(a[7:2])] = 1'b1;
      end else begin
        case (a[4:2])
          3'd0: led_m = d[7:0];
          3'd1: if (!full_b || popd) q.push_back(d[7:0]); else ovf_m = 1'b1;
          3'd2: if (d[2]) ovf_m = 1'b0;
`ifdef DMEM_MMIO_CYCLE_EN
          3'd3: cyc_m = d;
`endif
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.mem_addr   = A_IDLE;
    bus.write_data = '0;
    bus.mem_write  = 1'b0;
    tx_ready       = 1'b0;
    reset          = 1'b0;
    model_reset();
    #2;
    checks++; if (led !== 8'h00) $display("FAIL reset_led: got %h expected 00", led); else passes++;
    checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); else passes++;
    drive(A_STATUS, 0, 1'b0, 1'b0);
    checks++; if (bus.read_data !== 32'h1) $display("FAIL reset_status: got %h expected 00000001", bus.read_data); else passes++;
    drive(A_CYCLE, 0, 1'b0, 1'b0);
    checks++; if (bus.read_data !== 32'h0) $display("FAIL reset_cycle: got %h expected 00000000", bus.read_data); else passes++;
    reset = 1'b1;
    drive(A_IDLE, 0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_ram();
    drive(32'h0000_0010, 32'h0, 1'b1, 1'b0);        tick();
    drive(32'h0000_0014, 32'h1122_3344, 1'b1, 1'b0); tick();
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    checks++; if (bus.read_data !== 32'h0) $display("FAIL ram_same_cycle_old: got %h expected 00000000", bus.read_data); else passes++;
    tick();
    drive(32'h0000_0010, 0, 1'b0, 1'b0);
    checks++; if (bus.read_data !== 32'hDEAD_BEEF) $display("FAIL ram_load: got %h expected deadbeef", bus.read_data); else passes++;
    drive(32'h0000_0110, 0, 1'b0, 1'b0);
    checks++; if (bus.read_data !== 32'hDEAD_BEEF) $display("FAIL ram_alias: got %h expected deadbeef", bus.read_data); else passes++;
    drive(32'h0000_0014, 0, 1'b0, 1'b0);
    checks++; if (bus.read_data !== 32'h1122_3344) $display("FAIL ram_neighbour: got %h expected 11223344", bus.read_data); else passes++;
    tick();
  endtask

  task automatic test_led_reset();
    drive(A_LED, 32'h1234_56A5, 1'b1, 1'b0); tick();
    drive(A_TX, 32'h77, 1'b1, 1'b0);         tick();
    drive(A_LED, 0, 1'b0, 1'b0);
    checks++; if (led !== 8'hA5) $display("FAIL led_out: got %h expected a5", led); else passes++;
    checks++; if (bus.read_data !== 32'hA5) $display("FAIL led_read: got %h expected 000000a5", bus.read_data); else passes++;
    checks++; if (tx_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b expected 1", tx_valid); else passes++;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (led !== 8'h00) $display("FAIL led_async_reset: got %h expected 00", led); else passes++;
    checks++; if (tx_valid !== 1'b0) $display("FAIL fifo_async_reset: got %b expected 0", tx_valid); else passes++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fifo_overflow();
    for (int i = 1; i <= 9; i++) begin
      drive(A_TX, i, 1'b1, 1'b0);
      tick();
    end
    drive(A_STATUS, 0, 1'b0, 1'b0);
    checks++; if (bus.read_data !== 32'h806) $display("FAIL status_overflow: got %h expected 00000806", bus.read_data); else passes++;
    for (int i = 1; i <= 8; i++) begin
      drive(A_IDLE, 0, 1'b0, 1'b1);
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) $display("FAIL drain_%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, 8'(i)); else passes++;
      tick();
    end
    drive(A_IDLE, 0, 1'b0, 1'b1);
    checks++; if (tx_valid !== 1'b0) $display("FAIL drain_empty: got %b expected 0", tx_valid); else passes++;
    drive(A_STATUS, 32'h4, 1'b1, 1'b0); tick();
    drive(A_STATUS, 0, 1'b0, 1'b0);
    checks++; if (bus.read_data !== 32'h1) $display("FAIL status_cleared: got %h expected 00000001", bus.read_data); else passes++;
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 8; i++) begin
      drive(A_TX, 32'h10 + i, 1'b1, 1'b0);
      tick();
    end
    drive(A_TX, 32'h55, 1'b1, 1'b1);
    checks++; if (tx_data !== 8'h10) $display("FAIL full_head: got %h expected 10", tx_data); else passes++;
    tick();
    drive(A_STATUS, 0, 1'b0, 1'b0);
    checks++; if (bus.read_data !== 32'h802) $display("FAIL full_pushpop_status: got %h expected 00000802", bus.read_data); else passes++;
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] want;
      want = (i == 8) ? 8'h55 : 8'(8'h10 + i);
      drive(A_IDLE, 0, 1'b0, 1'b1);
      checks++; if (tx_valid !== 1'b1 || tx_data !== want) $display("FAIL pushpop_order_%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, want); else passes++;
      tick();
    end
  endtask

  task automatic test_back_pressure();
    drive(A_TX, 32'hAA, 1'b1, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(A_IDLE, 0, 1'b0, 1'b0);
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA) $display("FAIL hold_%0d: got v=%b d=%h expected v=1 d=aa", i, tx_valid, tx_data); else passes++;
      tick();
    end
    drive(A_IDLE, 0, 1'b0, 1'b1);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA) $display("FAIL release: got v=%b d=%h expected v=1 d=aa", tx_valid, tx_data); else passes++;
    tick();
    drive(A_IDLE, 0, 1'b0, 1'b0);
    checks++; if (tx_valid !== 1'b0) $display("FAIL popped_once: got %b expected 0", tx_valid); else passes++;
  endtask

  task automatic test_cycle();
    logic [31:0] want [3];
`ifdef DMEM_MMIO_CYCLE_EN
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0;
`else
    want[0] = 32'h0; want[1] = 32'h0; want[2] = 32'h0;
`endif
    drive(A_CYCLE, 32'hFFFF_FFFE, 1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(A_CYCLE, 0, 1'b0, 1'b0);
      checks++; if (bus.read_data !== want[i]) $display("FAIL cycle_%0d: got %h expected %h", i, bus.read_data, want[i]); else passes++;
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] exp;
    bit          known;
    int          op;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      a  = $urandom;
      if (op <= 3) a[31] = 1'b0;
      else begin
        a[31] = 1'b1;
        case (op)
          4, 5:    a[4:2] = 3'd1;
          6:       a[4:2] = 3'd0;
          7:       a[4:2] = 3'd2;
          8:       a[4:2] = 3'd3;
          default: a[4:2] = 3'($urandom_range(4, 7));
        endcase
      end
      drive(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0 ? 0 : 1));
      exp = exp_read(a, known);
      if (known) begin
        checks++; if (bus.read_data !== exp) $display("FAIL rnd_read_%0d: addr %h got %h expected %h", n, a, bus.read_data, exp); else passes++;
      end
      checks++; if (tx_valid !== (q.size() != 0)) $display("FAIL rnd_valid_%0d: got %b expected %b", n, tx_valid, q.size() != 0); else passes++;
      if (q.size() != 0) begin
        checks++; if (tx_data !== q[0]) $display("FAIL rnd_data_%0d: got %h expected %h", n, tx_data, q[0]); else passes++;
      end
      checks++; if (led !== led_m) $display("FAIL rnd_led_%0d: got %h expected %h", n, led, led_m); else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led_reset();
    test_fifo_overflow();
    test_push_pop_full();
    test_back_pressure();
    test_cycle();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
